// File: rtl/dram_responder.sv
// Block-read memory target: acks one request, then returns a 64 B line as 8 beats.
// Latency: reqack one cycle after reqcyc is sampled; first beat LATENCY+1 cycles after reqack.
// Backpressure: each beat is held with respcyc high until respack; new requests wait for IDLE.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   m_bus_reqcyc/reqack - request valid / one-cycle acknowledge
//   m_bus_req/reqtag    - request byte address / tag
//   m_bus_respcyc/ack   - response beat valid / initiator acknowledge
//   m_bus_resp/resptag  - response beat data / tag of request being answered
//   init_we/addr/data   - backdoor store write (effective only in IDLE)
//   busy                - high whenever a request is in flight
module dram_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 4,
    parameter int BEATS          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_bus_reqcyc,
    output logic                         m_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]    m_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     m_bus_reqtag,
    output logic                         m_bus_respcyc,
    input  logic                         m_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]    m_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     m_bus_resptag,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data,
    output logic                         busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    // Byte offset within a line: BEATS words of 8 bytes each.
    localparam int OFS_W = BW + 3;
    localparam int LINE_W = AW - BW;
    localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [LW-1:0]       lat_q, lat_d;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                      mem_we;

    // Only the line-index bits of the address matter: the offset within the
    // line is ignored and everything above the store size wraps.
    logic unused_req_bits;
    assign unused_req_bits = ^{m_bus_req[BUS_DATA_WIDTH-1:AW+3], m_bus_req[OFS_W-1:0]};

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        tag_d         = tag_q;
        beat_d        = beat_q;
        lat_d         = lat_q;
        m_bus_reqack  = 1'b0;
        m_bus_respcyc = 1'b0;
        m_bus_resp    = '0;
        m_bus_resptag = '0;
        busy          = (state_q != ST_IDLE);
        // Backdoor writes are locked out while a line is being served so the
        // data already promised to the initiator cannot change under it.
        mem_we        = init_we && (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (m_bus_reqcyc) begin
                    line_d  = m_bus_req[AW+2:OFS_W];
                    tag_d   = m_bus_reqtag;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                m_bus_reqack = 1'b1;
                lat_d        = LW'(LATENCY);
                state_d      = (LATENCY > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                // Leave on the cycle the counter shows 1 so the number of
                // WAIT cycles equals LATENCY exactly.
                lat_d = lat_q - 1'b1;
                if (lat_q <= LW'(1)) begin
                    lat_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                m_bus_respcyc = 1'b1;
                m_bus_resptag = tag_q;
                m_bus_resp    = mem[{line_q, beat_q}];
                if (m_bus_respack) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[init_addr] <= init_data;
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
module tb_dram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reqcyc    [2];
    logic [63:0] req       [2];
    logic [12:0] reqtag    [2];
    logic        respack   [2];
    logic        init_we   [2];
    logic [11:0] init_addr [2];
    logic [63:0] init_data [2];

    logic        reqack0, reqack1, respcyc0, respcyc1, busy0, busy1;
    logic [63:0] resp0, resp1;
    logic [12:0] resptag0, resptag1;

    // Unit 0: default store, LATENCY=4. Unit 1: small store, LATENCY=0.
    dram_responder #(.MEM_WORDS(4096), .LATENCY(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .m_bus_reqcyc(reqcyc[0]), .m_bus_reqack(reqack0),
        .m_bus_req(req[0]), .m_bus_reqtag(reqtag[0]),
        .m_bus_respcyc(respcyc0), .m_bus_respack(respack[0]),
        .m_bus_resp(resp0), .m_bus_resptag(resptag0),
        .init_we(init_we[0]), .init_addr(init_addr[0]), .init_data(init_data[0]),
        .busy(busy0)
    );

    dram_responder #(.MEM_WORDS(128), .LATENCY(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .m_bus_reqcyc(reqcyc[1]), .m_bus_reqack(reqack1),
        .m_bus_req(req[1]), .m_bus_reqtag(reqtag[1]),
        .m_bus_respcyc(respcyc1), .m_bus_respack(respack[1]),
        .m_bus_resp(resp1), .m_bus_resptag(resptag1),
        .init_we(init_we[1]), .init_addr(init_addr[1][6:0]), .init_data(init_data[1]),
        .busy(busy1)
    );

    int          words  [2] = '{4096, 128};
    int          lat_of [2] = '{4, 0};
    logic [63:0] mdl    [2][4096];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [63:0] o_ack(input int s);
        return (s == 0) ? 64'(reqack0) : 64'(reqack1);
    endfunction
    function automatic logic [63:0] o_cyc(input int s);
        return (s == 0) ? 64'(respcyc0) : 64'(respcyc1);
    endfunction
    function automatic logic [63:0] o_busy(input int s);
        return (s == 0) ? 64'(busy0) : 64'(busy1);
    endfunction
    function automatic logic [63:0] o_resp(input int s);
        return (s == 0) ? resp0 : resp1;
    endfunction
    function automatic logic [63:0] o_tag(input int s);
        return (s == 0) ? 64'(resptag0) : 64'(resptag1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int s, input string tag);
        chk({tag, "_reqack"}, o_ack(s), 0);
        chk({tag, "_respcyc"}, o_cyc(s), 0);
        chk({tag, "_resp"}, o_resp(s), 0);
        chk({tag, "_resptag"}, o_tag(s), 0);
        chk({tag, "_busy"}, o_busy(s), 0);
    endtask

    // Backdoor write while the unit is idle; the model follows it.
    task automatic bd_write(input int s, input int a, input logic [63:0] d);
        init_we[s]   = 1'b1;
        init_addr[s] = 12'(a);
        init_data[s] = d;
        tick;
        init_we[s] = 1'b0;
        mdl[s][a & (words[s] - 1)] = d;
    endtask

    // One block read. mode: 0 ack every cycle, 1 ack pattern 1,0,0,..., 2 random.
    // hold keeps reqcyc high throughout; junk aims backdoor writes at the line
    // while the unit is busy; nbeats < 8 stops with beat nbeats on the bus.
    task automatic do_read(input int s, input logic [63:0] addr, input logic [12:0] tag,
                           input int mode, input bit hold, input bit junk, input int nbeats);
        logic [63:0] exp [8];
        logic [63:0] lb;
        int beats, guard, p;
        bit ack;
        lb = (addr >> 6) << 3;
        for (int i = 0; i < 8; i++)
            exp[i] = mdl[s][int'((lb + 64'(i)) & 64'(words[s] - 1))];

        req[s]    = addr;
        reqtag[s] = tag;
        reqcyc[s] = 1'b1;
        tick;
        init_we[s] = 1'b0;
        chk("ack_reqack", o_ack(s), 1);
        chk("ack_busy", o_busy(s), 1);
        chk("ack_respcyc", o_cyc(s), 0);
        if (!hold) reqcyc[s] = 1'b0;

        for (int k = 0; k < lat_of[s] + 1; k++) begin
            respack[s] = 1'($urandom_range(0, 1));
            if (junk) begin
                init_we[s]   = 1'b1;
                init_addr[s] = 12'((lb + 64'($urandom_range(0, 7))) & 64'(words[s] - 1));
                init_data[s] = {$urandom, $urandom};
            end
            tick;
            if (k < lat_of[s]) begin
                chk("wait_respcyc", o_cyc(s), 0);
                chk("wait_reqack", o_ack(s), 0);
            end
        end

        beats = 0;
        guard = 0;
        p     = 0;
        while (beats < nbeats && guard < 100) begin
            chk("beat_respcyc", o_cyc(s), 1);
            chk("beat_data", o_resp(s), exp[beats]);
            chk("beat_tag", o_tag(s), 64'(tag));
            chk("beat_reqack", o_ack(s), 0);
            case (mode)
                0:       ack = 1'b1;
                1:       ack = (p % 3 == 0);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            p++;
            respack[s] = ack;
            if (junk) begin
                init_we[s]   = 1'b1;
                init_addr[s] = 12'((lb + 64'($urandom_range(0, 7))) & 64'(words[s] - 1));
                init_data[s] = {$urandom, $urandom};
            end
            tick;
            if (ack) beats++;
            guard++;
        end
        if (guard >= 100) chk("beat_timeout", 64'(guard), 0);
        respack[s] = 1'b0;
        init_we[s] = 1'b0;
        if (nbeats == 8) begin
            chk("end_respcyc", o_cyc(s), 0);
            chk("end_busy", o_busy(s), 0);
            chk("end_resp", o_resp(s), 0);
            chk("end_resptag", o_tag(s), 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            reqcyc[s] = 1'b0; req[s] = '0; reqtag[s] = '0; respack[s] = 1'b0;
            init_we[s] = 1'b0; init_addr[s] = '0; init_data[s] = '0;
        end
        tick;
        tick;
        check_quiet(0, "rst0");
        check_quiet(1, "rst1");
        reset = 1'b0;

        // Preload both stores; words 0x40..0x47 get 0xA0..0xA7.
        for (int i = 0; i < 4096; i++) begin
            logic [63:0] d0, d1;
            d0 = (i >= 'h40 && i < 'h48) ? 64'('hA0 + i - 'h40) : {$urandom, $urandom};
            d1 = (i >= 'h40 && i < 'h48) ? 64'('hA0 + i - 'h40) : {$urandom, $urandom};
            init_we[0] = 1'b1; init_addr[0] = 12'(i); init_data[0] = d0;
            mdl[0][i] = d0;
            init_we[1] = (i < 128); init_addr[1] = 12'(i & 127); init_data[1] = d1;
            if (i < 128) mdl[1][i] = d1;
            tick;
        end
        init_we[0] = 1'b0;
        init_we[1] = 1'b0;
        tick;
        check_quiet(0, "idle0");

        // Directed reads on the LATENCY=4 unit.
        do_read(0, 64'h200, 13'h15, 0, 1'b0, 1'b0, 8);
        do_read(0, 64'h200, 13'h15, 1, 1'b0, 1'b0, 8);
        do_read(0, 64'h23F, 13'h07, 0, 1'b0, 1'b0, 8);
        do_read(0, 64'h8000_0000_0000_0200, 13'h1FFF, 2, 1'b0, 1'b0, 8);

        // reqcyc held high through WAIT/RESP, then re-accepted in IDLE.
        do_read(0, 64'h200, 13'h03, 2, 1'b1, 1'b0, 8);
        do_read(0, 64'h1C0, 13'h04, 0, 1'b0, 1'b0, 8);

        // Reset after three beats abandons the line.
        do_read(0, 64'h200, 13'h09, 0, 1'b0, 1'b0, 3);
        reset = 1'b1;
        tick;
        check_quiet(0, "midrst");
        reset = 1'b0;
        do_read(0, 64'h200, 13'h0A, 0, 1'b0, 1'b0, 8);

        // LATENCY=0 unit: writes while busy are ignored, IDLE write is seen.
        do_read(1, 64'h200, 13'h11, 0, 1'b0, 1'b1, 8);
        init_we[1]   = 1'b1;
        init_addr[1] = 12'h40;
        init_data[1] = 64'h5555_AAAA_1234_5678;
        mdl[1][64]   = 64'h5555_AAAA_1234_5678;
        do_read(1, 64'h200, 13'h12, 1, 1'b0, 1'b0, 8);
        do_read(1, 64'h8000_0000_0000_0200, 13'h13, 0, 1'b0, 1'b0, 8);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int s;
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                bd_write(s, int'($urandom_range(0, 4095)), {$urandom, $urandom});
            do_read(s, {$urandom, $urandom}, 13'($urandom), int'($urandom_range(0, 2)),
                    1'b0, 1'($urandom_range(0, 1)), 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
Memory-side responder for the 64-bit Sysbus request/response handshake. It is the target that the set-associative cache's miss path talks to. It accepts one block-read request at a time, acknowledges it, waits a programmable latency, then returns one 64-byte line as 8 × 64-bit beats. Each beat is held until the initiator acknowledges it. A backdoor write port preloads the backing store for simulation and bring-up.

Parameters:
BUS_DATA_WIDTH, 64, data/address bus width
BUS_TAG_WIDTH, 13, request/response tag width
MEM_WORDS, 4096, backing store depth in 64-bit words; must be a power of 2 and ≥ 8
LATENCY, 4, idle cycles between the reqack cycle and the first response beat; 0 is legal
BEATS, 8, beats per line (fixed at 8; line = 64 B)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
m_bus_reqcyc  in  1  initiator request valid
m_bus_reqack  out  1  one-cycle request acknowledge
m_bus_req  in  64  byte address of request
m_bus_reqtag  in  13  request tag
m_bus_respcyc  out  1  response beat valid
m_bus_respack  in  1  initiator beat acknowledge
m_bus_resp  out  64  response beat data
m_bus_resptag  out  13  tag of request being answered
init_we  in  1  backdoor write enable
init_addr  in  log2(MEM_WORDS)  backdoor word index
init_data  in  64  backdoor write data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, sampled on posedge: state=IDLE. All outputs (m_bus_reqack, m_bus_respcyc, m_bus_resp, m_bus_resptag, busy) = 0. Beat counter and latency counter = 0. Memory contents are preserved, not cleared. Reset mid-transaction abandons it with no further beats.
- States: IDLE, ACK, WAIT, RESP.
- IDLE: if reqcyc=1 on a posedge, capture req_addr and req_tag, then go to ACK. Otherwise stay in IDLE.
- ACK: reqack=1 for exactly this one cycle. Load latency counter with LATENCY. Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT: decrement the counter each cycle. Go to RESP on the cycle the counter reaches 1, so exactly LATENCY cycles are spent in WAIT.
- RESP:
  - respcyc=1; resptag=captured tag; resp=mem[(line_base + beat) mod MEM_WORDS].
  - line_base = req_addr[3+log2(MEM_WORDS)-1:6] << 3. Address bits [5:0] are ignored, and upper address bits are truncated (address space wraps).
  - Beats are returned in ascending order, beat 0 first. Beat i maps to bits [64i+63:64i] of the initiator's line.
  - A beat is transferred on a posedge where respcyc=1 and respack=1. The beat counter then increments and the next beat is presented the following cycle, with respcyc staying high.
  - If respack=0, hold resp/resptag stable indefinitely.
  - After beat 7 transfers: beat counter=0, go to IDLE, respcyc=0 the next cycle.
- First-beat latency: reqcyc sampled at cycle T → reqack at T+1 → first beat valid at T+2+LATENCY.
- reqcyc while not in IDLE is ignored (no ack, nothing queued). The initiator must drop reqcyc after seeing reqack. If reqcyc is still high on return to IDLE, it is treated as a new request.
- respack while respcyc=0 is ignored.
- Backdoor write: applied only when state=IDLE; mem[init_addr] ← init_data. init_we is ignored in all other states, so in-flight data is never corrupted. Simultaneous init_we and reqcyc in IDLE: the write commits and the request is captured, and the read sees the new value.
- When respcyc=0, m_bus_resp/resptag are driven to 0.

Test Plan:
- Preload words 0x40–0x47 with 0xA0..0xA7; LATENCY=4; request addr 0x200, tag 0x15, respack always 1 → reqack one cycle at T+1; beats 0xA0..0xA7 on 8 consecutive cycles starting T+6; resptag=0x15 throughout; then IDLE and busy=0.
- Same request with respack toggled 1,0,0,1,… → each beat held stable until acked; total beats=8, no skips or repeats.
- Request addr 0x23F (offset bits set) → same 8 beats as 0x200; addr with bits above index set (e.g. 0x8000_0000_0000_0200) → identical data (wrap/truncate).
- Second reqcyc asserted during WAIT and RESP → no extra reqack; after IDLE with reqcyc still high → new ack and a full second line.
- Assert reset during RESP after 3 beats → next cycle respcyc=0, busy=0; the following request returns preloaded data unchanged from beat 0.
- LATENCY=0 build: first beat at T+2. init_we to word 0x40 during RESP → ignored (beat shows old 0xA0); the same write in IDLE → read returns the new value.
